// File: rtl/pipeline_debug_unit_pkg.sv
// pipeline_debug_unit_pkg: host command codes, controller states and dump framing constants
package pipeline_debug_unit_pkg;
    localparam logic [7:0] CMD_RUN = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam int DUMP_BYTES = 136;
    localparam int DBG_BYTE_IDX_BITS = 8;
    typedef enum logic [2:0] {IDLE, RUN, STEP, DUMP, DONE} state_t;
endpackage

// File: rtl/pipeline_debug_unit_if.sv
// pipeline_debug_unit_if: host byte link, command bytes in and dump bytes out
interface pipeline_debug_unit_if;
    logic [7:0] rx_data;
    logic rx_valid;
    logic rx_ready;
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    modport master (output rx_data, rx_valid, tx_ready, input rx_ready, tx_data, tx_valid);
    modport slave (input rx_data, rx_valid, tx_ready, output rx_ready, tx_data, tx_valid);
endinterface

// File: rtl/pipeline_debug_unit_dump_byte_mux.sv
// pipeline_debug_unit_dump_byte_mux: selects dump byte idx from the little-endian frame {regs, count, pc}
module pipeline_debug_unit_dump_byte_mux #(
    parameter int PROC_BITS = 32,
    parameter int PC_BITS = 32,
    parameter int NUM_REGS = 32
) (
    input logic [7:0] idx,
    input logic [NUM_REGS*PROC_BITS-1:0] regs,
    input logic [31:0] count,
    input logic [PC_BITS-1:0] pc,
    output logic [7:0] data
);
    localparam int W = NUM_REGS*PROC_BITS + 64;
    logic [W-1:0] frame;
    assign frame = {regs, count, 32'(pc)};
    assign data = 8'(frame >> {idx, 3'b000});
endmodule

// File: rtl/pipeline_debug_unit.sv
// pipeline_debug_unit: host-driven run/step/halt sequencing of the pipeline plus state dump streaming
module pipeline_debug_unit
    import pipeline_debug_unit_pkg::*;
#(
    parameter int PROC_BITS = 32,
    parameter int PC_BITS = 32,
    parameter int NUM_REGS = 32
) (
    input logic clk,
    input logic rst,
    pipeline_debug_unit_if.slave bus,
    input logic [NUM_REGS*PROC_BITS-1:0] rf_regs,
    input logic [PC_BITS-1:0] pc,
    input logic halt,
    output logic pipe_enable,
    output logic done
);
    state_t state, state_n;
    logic [DBG_BYTE_IDX_BITS-1:0] idx;
    logic [31:0] count;
    logic [7:0] byte_out;
    logic accept, last, shake;
    assign bus.rx_ready = state == IDLE || state == DONE;
    assign bus.tx_valid = state == DUMP;
    assign bus.tx_data = bus.tx_valid ? byte_out : 8'h00;
    assign accept = bus.rx_valid && bus.rx_ready;
    assign shake = bus.tx_valid && bus.tx_ready;
    assign last = idx == DBG_BYTE_IDX_BITS'(DUMP_BYTES - 1);
    pipeline_debug_unit_dump_byte_mux #(
        .PROC_BITS(PROC_BITS), .PC_BITS(PC_BITS), .NUM_REGS(NUM_REGS)
    ) mux (
        .idx(idx), .regs(rf_regs), .count(count), .pc(pc), .data(byte_out)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = bus.rx_data == CMD_RUN ? RUN :
                                        bus.rx_data == CMD_STEP ? STEP :
                                        bus.rx_data == CMD_DUMP ? DUMP : IDLE;
            RUN: if (halt) state_n = DUMP;
            STEP: state_n = DUMP;
            DUMP: if (shake && last) state_n = done ? DONE : IDLE;
            DONE: if (accept && bus.rx_data == CMD_DUMP) state_n = DUMP;
            default: state_n = IDLE;
        endcase
    end
    // enable tracks the next state so it is a true register yet matches RUN/STEP exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pipe_enable <= 1'b0;
            done <= 1'b0;
            count <= '0;
            idx <= '0;
        end else begin
            state <= state_n;
            pipe_enable <= state_n == RUN || state_n == STEP;
            if (pipe_enable) count <= count + 32'd1;
            if (pipe_enable && halt) done <= 1'b1;
            if (shake) idx <= last ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_debug_unit.sv
// tb_pipeline_debug_unit: directed sequence covering reset, commands, step/run/halt and dump framing
module tb_pipeline_debug_unit;
    logic clk = 1'b0;
    logic rst;
    logic [1023:0] regs;
    logic [31:0] pc;
    logic halt, pe, done;
    int n_asserts = 0;
    int n_fails = 0;
    pipeline_debug_unit_if bus();
    pipeline_debug_unit dut (
        .clk(clk), .rst(rst), .bus(bus), .rf_regs(regs), .pc(pc),
        .halt(halt), .pipe_enable(pe), .done(done)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [7:0] b);
        chk("rx_ready_before_cmd", 32'(bus.rx_ready), 32'd1);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask
    function automatic logic [7:0] exp_byte(input logic [31:0] p, input logic [31:0] c,
                                            input logic [1023:0] r, input int i);
        logic [31:0] w;
        w = i < 4 ? p : i < 8 ? c : r[(i/4-2)*32 +: 32];
        return w[(i%4)*8 +: 8];
    endfunction
    task automatic set_regs(input logic [31:0] base, input logic [31:0] step);
        for (int k = 0; k < 32; k++) regs[k*32 +: 32] = base + step * k;
    endtask
    // starts on the first DUMP cycle; collects up to limit handshakes
    task automatic dump(input string tag, input logic [31:0] ecnt, input bit stall, input int limit);
        int got, cyc, bad, held_bad, first_bad;
        logic [7:0] held, first_obs;
        bit was_stalled;
        got = 0; cyc = 0; bad = 0; held_bad = 0; first_bad = -1;
        held = 8'h00; first_obs = 8'h00; was_stalled = 1'b0;
        chk({tag, "_valid_first"}, 32'(bus.tx_valid), 32'd1);
        chk({tag, "_pe_off"}, 32'(pe), 32'd0);
        while (got < limit && cyc < 2000) begin
            bus.tx_ready = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            if (was_stalled && bus.tx_data !== held) held_bad++;
            was_stalled = bus.tx_valid && !bus.tx_ready;
            held = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) begin
                if (bus.tx_data !== exp_byte(pc, ecnt, regs, got)) begin
                    if (first_bad < 0) begin first_bad = got; first_obs = bus.tx_data; end
                    bad++;
                end
                got++;
            end
            tick();
            cyc++;
        end
        bus.tx_ready = 1'b1;
        chk({tag, "_handshakes"}, 32'(got), 32'(limit));
        chk({tag, "_byte_errors"}, 32'(bad), 32'd0);
        if (first_bad >= 0)
            chk({tag, "_first_bad_byte"}, 32'(first_obs), 32'(exp_byte(pc, ecnt, regs, first_bad)));
        chk({tag, "_held_errors"}, 32'(held_bad), 32'd0);
        chk({tag, "_cycles"}, 32'(cyc), stall ? 32'(limit * 2) : 32'(limit));
        if (limit == 136) begin
            chk({tag, "_valid_after"}, 32'(bus.tx_valid), 32'd0);
            chk({tag, "_rx_ready_after"}, 32'(bus.rx_ready), 32'd1);
        end
    endtask
    initial begin
        int en;
        rst = 1'b1; halt = 1'b0; pc = 32'h10; regs = '0;
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b1;
        set_regs(32'd0, 32'd1);
        tick(); tick();
        chk("rst_pe", 32'(pe), 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_rx_ready", 32'(bus.rx_ready), 32'd1);
        send(8'h41);
        chk("inv_pe", 32'(pe), 32'd0);
        chk("inv_rx_ready", 32'(bus.rx_ready), 32'd1);
        chk("inv_tx_valid", 32'(bus.tx_valid), 32'd0);
        send(8'h44);
        dump("dump0", 32'd0, 1'b0, 136);
        chk("dump0_done", 32'(done), 32'd0);
        for (int s = 1; s <= 3; s++) begin
            pc = 32'h100 + 32'(s * 4);
            send(8'h53);
            chk("step_pe_on", 32'(pe), 32'd1);
            tick();
            chk("step_pe_off", 32'(pe), 32'd0);
            dump("step_dump", 32'(s), 1'b0, 136);
        end
        rst = 1'b1; tick(); rst = 1'b0; tick();
        pc = 32'h0000_00C8;
        send(8'h43);
        en = 0;
        for (int i = 0; i < 50; i++) begin
            if (pe) en++;
            tick();
        end
        halt = 1'b1;
        if (pe) en++;
        tick();
        halt = 1'b0;
        chk("run_enabled_cycles", 32'(en), 32'd51);
        chk("run_done", 32'(done), 32'd1);
        dump("run_dump", 32'h33, 1'b0, 136);
        send(8'h43);
        chk("done_c_pe", 32'(pe), 32'd0);
        chk("done_c_rx_ready", 32'(bus.rx_ready), 32'd1);
        tick();
        chk("done_c_pe_later", 32'(pe), 32'd0);
        chk("done_c_tx_valid", 32'(bus.tx_valid), 32'd0);
        set_regs(32'hC0DE_0000, 32'h0000_0101);
        send(8'h44);
        dump("stall_dump", 32'h33, 1'b1, 136);
        chk("stall_done_sticky", 32'(done), 32'd1);
        pc = 32'h0040_1234;
        send(8'h44);
        dump("partial_dump", 32'h33, 1'b0, 70);
        rst = 1'b1;
        tick();
        chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("midrst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("midrst_pe", 32'(pe), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rx_ready", 32'(bus.rx_ready), 32'd1);
        rst = 1'b0;
        tick();
        send(8'h44);
        dump("restart_dump", 32'd0, 1'b0, 136);
        chk("restart_done", 32'(done), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
